// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between CPU, PS2 writer and display reader (optional starvation guard via RAMARB_STARVE_GUARD_EN)
module ram_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              ps2_req,
  input  logic [ADDR_W-1:0] ps2_addr,
  input  logic [DATA_W-1:0] ps2_wdata,
  output logic              ps2_gnt,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [1:0]        owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;
  state_t state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d, rdata_q, rdata_d;
  logic rv_q, rv_d;
  logic ps2_starved, disp_starved, cpu_win, ps2_win, disp_win, issue;
  assign issue = state_q == ISSUE;
`ifdef RAMARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] ps2_cnt_q, ps2_cnt_d, disp_cnt_q, disp_cnt_d;
  assign ps2_starved  = ps2_req && ps2_cnt_q == CW'(STARVE_LIMIT);
  assign disp_starved = disp_req && disp_cnt_q == CW'(STARVE_LIMIT);
  always_comb begin
    ps2_cnt_d  = (!ps2_req || ps2_gnt) ? '0 : (ps2_cnt_q == CW'(STARVE_LIMIT)) ? ps2_cnt_q : ps2_cnt_q + 1'b1;
    disp_cnt_d = (!disp_req || disp_gnt) ? '0 : (disp_cnt_q == CW'(STARVE_LIMIT)) ? disp_cnt_q : disp_cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_cnt_q  <= '0;
      disp_cnt_q <= '0;
    end else begin
      ps2_cnt_q  <= ps2_cnt_d;
      disp_cnt_q <= disp_cnt_d;
    end
  end
`else
  assign ps2_starved  = 1'b0;
  assign disp_starved = 1'b0;
`endif
  // a starved PS2 beats a starved display, and either beats the CPU
  assign cpu_win  = cpu_req && !ps2_starved && !disp_starved;
  assign ps2_win  = ps2_starved || (ps2_req && !cpu_req && !disp_starved);
  assign disp_win = !ps2_starved && (disp_starved || (disp_req && !cpu_req && !ps2_req));
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    rv_d    = 1'b0;
    case (state_q)
      IDLE: if (cpu_win || ps2_win || disp_win) begin
        state_d = ISSUE;
        owner_d = cpu_win ? 2'd1 : ps2_win ? 2'd2 : 2'd3;
        we_d    = cpu_win ? cpu_we : ps2_win;
        addr_d  = cpu_win ? cpu_addr : ps2_win ? ps2_addr : disp_addr;
        din_d   = cpu_win ? cpu_wdata : ps2_win ? ps2_wdata : din_q;
      end
      ISSUE: state_d = we_q ? IDLE : RWAIT;
      RWAIT: begin
        rdata_d = ram_dout;
        rv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
    end
  end
  // address/data latches drive the RAM directly, so they hold outside ISSUE
  assign ram_addr    = addr_q;
  assign ram_din     = din_q;
  assign ram_we      = issue && we_q;
  assign cpu_gnt     = issue && owner_q == 2'd1;
  assign ps2_gnt     = issue && owner_q == 2'd2;
  assign disp_gnt    = issue && owner_q == 2'd3;
  assign cpu_rvalid  = rv_q && owner_q == 2'd1;
  assign disp_rvalid = rv_q && owner_q == 2'd3;
  assign rdata       = rdata_q;
  assign owner       = owner_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed tests of ram_port_arbiter against a 1-cycle-latency RAM model
module tb_ram_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 0, cpu_we = 0, ps2_req = 0, disp_req = 0;
  logic [9:0] cpu_addr = 0, ps2_addr = 0, disp_addr = 0;
  logic [31:0] cpu_wdata = 0, ps2_wdata = 0;
  logic cpu_gnt, cpu_rvalid, ps2_gnt, disp_gnt, disp_rvalid, ram_we;
  logic [31:0] rdata, ram_din, ram_dout;
  logic [9:0] ram_addr;
  logic [1:0] owner;
  logic [31:0] mem [1024];
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .ps2_req(ps2_req), .ps2_addr(ps2_addr), .ps2_wdata(ps2_wdata), .ps2_gnt(ps2_gnt),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .owner(owner)
  );

  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_run++;
    if ({cpu_gnt, ps2_gnt, disp_gnt, cpu_rvalid, disp_rvalid, ram_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {cpu_gnt, ps2_gnt, disp_gnt, cpu_rvalid, disp_rvalid, ram_we});
    end
    n_run++;
    if ({owner, rdata, ram_addr, ram_din} !== 76'h0) begin
      n_fail++; $display("FAIL reset_data: owner %0h rdata %0h addr %0h din %0h expected all 0", owner, rdata, ram_addr, ram_din);
    end
    rst = 1'b0;
  endtask

  task automatic test_cpu_write();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h005; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_run++;
    if ({cpu_gnt, ram_we, owner} !== 4'b1101) begin
      n_fail++; $display("FAIL cpu_write_gnt: gnt/we/owner %b expected 1101", {cpu_gnt, ram_we, owner});
    end
    n_run++;
    if (ram_addr !== 10'h005 || ram_din !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL cpu_write_bus: addr %0h din %0h expected 5 deadbeef", ram_addr, ram_din);
    end
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    n_run++;
    if ({cpu_gnt, ram_we} !== 2'b00 || ram_addr !== 10'h005) begin
      n_fail++; $display("FAIL cpu_write_idle: gnt/we %b addr %0h expected 00 5", {cpu_gnt, ram_we}, ram_addr);
    end
  endtask

  task automatic test_disp_read();
    disp_req = 1; disp_addr = 10'h005;
    @(negedge clk);
    n_run++;
    if ({disp_gnt, ram_we, owner} !== 4'b1011) begin
      n_fail++; $display("FAIL disp_read_gnt: gnt/we/owner %b expected 1011", {disp_gnt, ram_we, owner});
    end
    disp_req = 0;
    @(negedge clk);
    n_run++;
    if (disp_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL disp_read_early: rvalid %b expected 0", disp_rvalid);
    end
    @(negedge clk);
    n_run++;
    if ({disp_rvalid, cpu_rvalid} !== 2'b10 || rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL disp_read_data: rv %b rdata %0h expected 10 deadbeef", {disp_rvalid, cpu_rvalid}, rdata);
    end
    @(negedge clk);
    n_run++;
    if (disp_rvalid !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL disp_read_pulse: rv %b rdata %0h expected 0 deadbeef", disp_rvalid, rdata);
    end
  endtask

  task automatic test_priority();
    int cpu_c = -1, ps2_c = -1, disp_c = -1, rv_c = -1;
    logic [31:0] rd = '0;
    logic multi = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 32'hA5A5_0001;
    ps2_req = 1; ps2_addr = 10'h011; ps2_wdata = 32'hB0B0_0002;
    disp_req = 1; disp_addr = 10'h010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if ($countones({cpu_gnt, ps2_gnt, disp_gnt}) > 1 || (cpu_rvalid && disp_rvalid)) multi = 1;
      if (cpu_gnt) begin cpu_c = c; cpu_req = 0; cpu_we = 0; end
      if (ps2_gnt) begin ps2_c = c; ps2_req = 0; end
      if (disp_gnt) begin disp_c = c; disp_req = 0; end
      if (disp_rvalid) begin rv_c = c; rd = rdata; end
    end
    n_run++;
    if (cpu_c != 1 || ps2_c != 3 || disp_c != 5) begin
      n_fail++; $display("FAIL prio_order: cpu %0d ps2 %0d disp %0d expected 1 3 5", cpu_c, ps2_c, disp_c);
    end
    n_run++;
    if (rv_c != 7 || rd !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL prio_read: rv cycle %0d rdata %0h expected 7 a5a50001", rv_c, rd);
    end
    n_run++;
    if (multi !== 1'b0 || mem[10'h011] !== 32'hB0B0_0002) begin
      n_fail++; $display("FAIL prio_onehot_ps2mem: multi %b mem %0h expected 0 b0b00002", multi, mem[10'h011]);
    end
  endtask

  task automatic test_ps2_cpu_read();
    ps2_req = 1; ps2_addr = 10'h020; ps2_wdata = 32'h1234_5678;
    @(negedge clk);
    n_run++;
    if ({ps2_gnt, ram_we, owner} !== 4'b1110) begin
      n_fail++; $display("FAIL ps2_write_gnt: gnt/we/owner %b expected 1110", {ps2_gnt, ram_we, owner});
    end
    ps2_req = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h020;
    @(negedge clk);
    n_run++;
    if ({cpu_gnt, ram_we} !== 2'b10 || ram_addr !== 10'h020) begin
      n_fail++; $display("FAIL cpu_read_gnt: gnt/we %b addr %0h expected 10 20", {cpu_gnt, ram_we}, ram_addr);
    end
    cpu_req = 0;
    @(negedge clk);
    disp_req = 1; disp_addr = 10'h005;
    @(negedge clk);
    n_run++;
    if ({cpu_rvalid, disp_rvalid} !== 2'b10 || rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL cpu_read_data: rv %b rdata %0h expected 10 12345678", {cpu_rvalid, disp_rvalid}, rdata);
    end
    @(negedge clk);
    n_run++;
    if ({disp_gnt, cpu_rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL rvalid_overlap: disp_gnt/cpu_rvalid %b expected 10", {disp_gnt, cpu_rvalid});
    end
    disp_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_withdraw();
    int seen = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h040; cpu_wdata = 32'h0000_0040;
    @(negedge clk);
    cpu_req = 0; cpu_we = 0;
    ps2_req = 1; ps2_addr = 10'h041; ps2_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    ps2_req = 0;
    repeat (5) begin
      @(negedge clk);
      if (ps2_gnt || ram_we) seen++;
    end
    n_run++;
    if (seen != 0 || mem[10'h041] !== 32'h0) begin
      n_fail++; $display("FAIL withdraw: grants %0d mem %0h expected 0 0", seen, mem[10'h041]);
    end
  endtask

  task automatic test_starve();
    int ps2_c = -1, cpu_n = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h030; cpu_wdata = 32'h3030_3030;
    ps2_req = 1; ps2_addr = 10'h031; ps2_wdata = 32'h3131_3131;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (cpu_gnt && ps2_c < 0) cpu_n++;
      if (ps2_gnt) begin ps2_c = c; ps2_req = 0; end
    end
    cpu_req = 0; cpu_we = 0; ps2_req = 0;
    repeat (3) @(negedge clk);
`ifdef RAMARB_STARVE_GUARD_EN
    n_run++;
    if (ps2_c != 9 || cpu_n != 4) begin
      n_fail++; $display("FAIL starve_guard: ps2 cycle %0d cpu grants %0d expected 9 4", ps2_c, cpu_n);
    end
`else
    n_run++;
    if (ps2_c != -1 || cpu_n != 20) begin
      n_fail++; $display("FAIL starve_none: ps2 cycle %0d cpu grants %0d expected -1 20", ps2_c, cpu_n);
    end
`endif
  endtask

  task automatic test_reset_rwait();
    int seen = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
    @(negedge clk);
    n_run++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rst_rwait_gnt: gnt %b expected 1", cpu_gnt);
    end
    cpu_req = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_run++;
    if ({cpu_gnt, ps2_gnt, disp_gnt, cpu_rvalid, disp_rvalid, ram_we, owner} !== 8'b0 || {rdata, ram_addr, ram_din} !== 74'h0) begin
      n_fail++; $display("FAIL rst_rwait_outs: ctrl %b rdata %0h addr %0h din %0h expected all 0",
        {cpu_gnt, ps2_gnt, disp_gnt, cpu_rvalid, disp_rvalid, ram_we, owner}, rdata, ram_addr, ram_din);
    end
    repeat (3) begin
      @(negedge clk);
      if (cpu_rvalid || cpu_gnt) seen++;
    end
    n_run++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_rwait_late: late pulses %0d expected 0", seen);
    end
    cpu_req = 1; cpu_addr = 10'h020;
    @(negedge clk);
    cpu_req = 0;
    repeat (2) @(negedge clk);
    n_run++;
    if (cpu_rvalid !== 1'b1 || rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rst_rwait_after: rv %b rdata %0h expected 1 12345678", cpu_rvalid, rdata);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_cpu_write();
    test_disp_read();
    test_priority();
    test_ps2_cpu_read();
    test_withdraw();
    test_starve();
    test_reset_rwait();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
